// File: rtl/pc_gen_pkg.sv
// Shared constants and state types for the IF-stage program-counter generator.
package pc_gen_pkg;

  localparam logic RST_ENABLE   = 1'b1;
  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;

  localparam int          INST_ADDR_W        = 32;
  localparam int          PC_INC_DEFAULT     = 4;
  localparam logic [31:0] RESET_VEC_DEFAULT  = 32'h0000_0000;

  // Externally visible view of the generator: fetch disabled, running, or branch buffered.
  typedef enum logic [1:0] {
    PC_IDLE = 2'd0,
    PC_RUN  = 2'd1,
    PC_PEND = 2'd2
  } pc_state_t;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_t;

endpackage

// File: rtl/pc_redirect_buf.sv
// Holds one branch target that arrived during a stall until the stall releases.
module pc_redirect_buf
  import pc_gen_pkg::*;
#(
  parameter int AW = INST_ADDR_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          clear,
  input  logic          take,
  input  logic [AW-1:0] tgt_i,
  output logic          pend_o,
  output logic [AW-1:0] tgt_o
);

  buf_state_t    state_q;
  buf_state_t    state_d;
  logic [AW-1:0] tgt_q;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) state_q <= BUF_EMPTY;
    else                   state_q <= state_d;
  end

  // load, clear and take are mutually exclusive by construction in pc_gen.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BUF_EMPTY: if (load)          state_d = BUF_FULL;
      BUF_FULL:  if (clear || take) state_d = BUF_EMPTY;
      default:                      state_d = BUF_EMPTY;
    endcase
  end

  // A later branch in the same stall simply overwrites the buffered target.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) tgt_q <= '0;
    else if (load)         tgt_q <= tgt_i;
  end

  assign pend_o = (state_q == BUF_FULL);
  assign tgt_o  = tgt_q;

endmodule

// File: rtl/pc_gen.sv
// IF-stage program counter with stall hold, branch redirect (buffered across stalls)
// and flush redirect. All outputs come straight from registers.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int            AW        = INST_ADDR_W,
  parameter logic [AW-1:0] RESET_VEC = AW'(RESET_VEC_DEFAULT),
  parameter int            INC       = PC_INC_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall_i,
  input  logic          flush_i,
  input  logic [AW-1:0] new_pc_i,
  input  logic          branch_flag_i,
  input  logic [AW-1:0] branch_target_i,
  output logic [AW-1:0] pc_o,
  output logic          ce_o,
  output logic          redirect_pend_o,
  output logic [1:0]    dbg_state_o
);

  localparam logic [AW-1:0] ALIGN_MASK = ~(AW'(INC - 1));
  localparam logic [AW-1:0] INC_W      = AW'(INC);

  logic          ce_q;
  logic [AW-1:0] pc_q;
  logic [AW-1:0] pc_d;
  logic          pend;
  logic [AW-1:0] pend_tgt;
  logic [AW-1:0] new_pc_al;
  logic [AW-1:0] branch_al;
  logic          do_flush;
  logic          do_stall;
  logic          do_branch;
  logic          buf_load;
  logic          buf_clear;
  logic          buf_take;
  pc_state_t     dbg_state;

  assign new_pc_al = new_pc_i & ALIGN_MASK;
  assign branch_al = branch_target_i & ALIGN_MASK;

  // One action per enabled edge: flush > stall > fresh branch > buffered branch > increment.
  assign do_flush  = ce_q && flush_i;
  assign do_stall  = ce_q && !flush_i && stall_i;
  assign do_branch = ce_q && !flush_i && !stall_i && branch_flag_i;
  assign buf_load  = do_stall && branch_flag_i;
  assign buf_clear = do_flush || do_branch;
  assign buf_take  = ce_q && !flush_i && !stall_i && !branch_flag_i && pend;

  pc_redirect_buf #(.AW(AW)) u_redirect_buf (
    .clk    (clk),
    .rst    (rst),
    .load   (buf_load),
    .clear  (buf_clear),
    .take   (buf_take),
    .tgt_i  (branch_al),
    .pend_o (pend),
    .tgt_o  (pend_tgt)
  );

  always_comb begin
    pc_d = pc_q;
    if (do_flush)       pc_d = new_pc_al;
    else if (do_stall)  pc_d = pc_q;
    else if (do_branch) pc_d = branch_al;
    else if (buf_take)  pc_d = pend_tgt;
    else if (ce_q)      pc_d = pc_q + INC_W;
  end

  // Chip enable rises one edge after reset release; that edge leaves the PC at RESET_VEC.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) ce_q <= CHIP_DISABLE;
    else                   ce_q <= CHIP_ENABLE;
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) pc_q <= RESET_VEC;
    else                   pc_q <= pc_d;
  end

  always_comb begin
    dbg_state = PC_RUN;
    if (!ce_q)     dbg_state = PC_IDLE;
    else if (pend) dbg_state = PC_PEND;
  end

  assign pc_o            = pc_q;
  assign ce_o            = ce_q;
  assign redirect_pend_o = pend;
  assign dbg_state_o     = dbg_state;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed vector table, random run against a reference model,
// and an 8-bit instance for wrap-around and alignment.
module tb_pc_gen;
  import pc_gen_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk;
  logic        rst, stall, flush, br;
  logic [31:0] new_pc, tgt;
  logic [31:0] pc;
  logic        ce, pend;
  logic [1:0]  dbg;

  logic        rst8, stall8, flush8, br8;
  logic [7:0]  new_pc8, tgt8, pc8;
  logic        ce8, pend8;
  logic [1:0]  dbg8;

  int errors = 0;
  int checks = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  pc_gen dut (
    .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush), .new_pc_i(new_pc),
    .branch_flag_i(br), .branch_target_i(tgt), .pc_o(pc), .ce_o(ce),
    .redirect_pend_o(pend), .dbg_state_o(dbg)
  );

  pc_gen #(.AW(8), .RESET_VEC(8'h00), .INC(4)) dut8 (
    .clk(clk), .rst(rst8), .stall_i(stall8), .flush_i(flush8), .new_pc_i(new_pc8),
    .branch_flag_i(br8), .branch_target_i(tgt8), .pc_o(pc8), .ce_o(ce8),
    .redirect_pend_o(pend8), .dbg_state_o(dbg8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst, stall, flush, br;
    logic [31:0] new_pc, tgt;
    logic [31:0] exp_pc;
    logic        exp_ce, exp_pend;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic s, input logic f, input logic [31:0] np,
                              input logic b, input logic [31:0] t,
                              input logic [31:0] epc, input logic ece, input logic epend);
    vec_t v;
    v.rst = r; v.stall = s; v.flush = f; v.new_pc = np; v.br = b; v.tgt = t;
    v.exp_pc = epc; v.exp_ce = ece; v.exp_pend = epend;
    return v;
  endfunction

  function automatic logic [1:0] exp_state(input logic c, input logic p);
    if (!c) return PC_IDLE;
    if (p)  return PC_PEND;
    return PC_RUN;
  endfunction

  // Drive one edge of inputs, then sample half a period later.
  task automatic drive(input logic r, input logic s, input logic f, input logic [31:0] np,
                       input logic b, input logic [31:0] t);
    rst = r; stall = s; flush = f; new_pc = np; br = b; tgt = t;
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- reference model + scoreboard ----------------
  logic [31:0] m_pc, m_tgt;
  logic        m_ce, m_pend;
  logic [33:0] exp_q[$];

  task automatic model_step(input logic r, input logic s, input logic f, input logic [31:0] np,
                            input logic b, input logic [31:0] t);
    if (r) begin
      m_ce = 0; m_pc = 32'h0; m_pend = 0; m_tgt = 32'h0;
    end else if (!m_ce) begin
      m_ce = 1;
    end else if (f) begin
      m_pc = np & ~32'd3; m_pend = 0;
    end else if (s) begin
      if (b) begin m_pend = 1; m_tgt = t & ~32'd3; end
    end else if (b) begin
      m_pc = t & ~32'd3; m_pend = 0;
    end else if (m_pend) begin
      m_pc = m_tgt; m_pend = 0;
    end else begin
      m_pc = m_pc + 32'd4;
    end
    exp_q.push_back({m_ce, m_pend, m_pc});
  endtask

  task automatic drive8(input logic r, input logic s, input logic f, input logic [7:0] np,
                        input logic b, input logic [7:0] t);
    rst8 = r; stall8 = s; flush8 = f; new_pc8 = np; br8 = b; tgt8 = t;
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [33:0] e;
    rst = 1; stall = 0; flush = 0; br = 0; new_pc = 0; tgt = 0;
    rst8 = 1; stall8 = 0; flush8 = 0; br8 = 0; new_pc8 = 0; tgt8 = 0;

    // reset, release, stall, buffered branch overwrite, flush over pend, fresh beats buffered, reset with pend
    vecs.push_back(mk(1,0,0,0,       0,0,        32'h000,0,0));
    vecs.push_back(mk(1,0,0,0,       0,0,        32'h000,0,0));
    vecs.push_back(mk(1,0,0,0,       0,0,        32'h000,0,0));
    vecs.push_back(mk(0,0,1,32'h77,  0,0,        32'h000,1,0));
    vecs.push_back(mk(0,0,0,0,       0,0,        32'h004,1,0));
    vecs.push_back(mk(0,0,0,0,       0,0,        32'h008,1,0));
    vecs.push_back(mk(0,0,0,0,       0,0,        32'h00C,1,0));
    vecs.push_back(mk(0,0,0,0,       0,0,        32'h010,1,0));
    vecs.push_back(mk(0,1,0,0,       0,0,        32'h010,1,0));
    vecs.push_back(mk(0,1,0,0,       0,0,        32'h010,1,0));
    vecs.push_back(mk(0,1,0,0,       0,0,        32'h010,1,0));
    vecs.push_back(mk(0,0,0,0,       0,0,        32'h014,1,0));
    vecs.push_back(mk(0,0,0,0,       0,0,        32'h018,1,0));
    vecs.push_back(mk(0,0,0,0,       0,0,        32'h01C,1,0));
    vecs.push_back(mk(0,0,0,0,       0,0,        32'h020,1,0));
    vecs.push_back(mk(0,1,0,0,       1,32'h100,  32'h020,1,1));
    vecs.push_back(mk(0,1,0,0,       1,32'h200,  32'h020,1,1));
    vecs.push_back(mk(0,0,0,0,       0,0,        32'h200,1,0));
    vecs.push_back(mk(0,0,0,0,       0,0,        32'h204,1,0));
    vecs.push_back(mk(0,1,0,0,       1,32'h300,  32'h204,1,1));
    vecs.push_back(mk(0,1,1,32'h180, 0,0,        32'h180,1,0));
    vecs.push_back(mk(0,0,0,0,       0,0,        32'h184,1,0));
    vecs.push_back(mk(0,0,0,0,       1,32'h10B,  32'h108,1,0));
    vecs.push_back(mk(0,1,0,0,       1,32'h1F2,  32'h108,1,1));
    vecs.push_back(mk(0,1,0,0,       0,0,        32'h108,1,1));
    vecs.push_back(mk(0,0,0,0,       1,32'h400,  32'h400,1,0));
    vecs.push_back(mk(0,0,0,0,       0,0,        32'h404,1,0));
    vecs.push_back(mk(0,1,0,0,       1,32'h500,  32'h404,1,1));
    vecs.push_back(mk(1,1,0,0,       1,32'h500,  32'h000,0,0));
    vecs.push_back(mk(0,1,0,0,       1,32'h600,  32'h000,1,0));
    vecs.push_back(mk(0,0,0,0,       0,0,        32'h004,1,0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].flush, vecs[i].new_pc, vecs[i].br, vecs[i].tgt);
      check($sformatf("vec%0d pc", i),   pc,   vecs[i].exp_pc);
      check($sformatf("vec%0d ce", i),   {31'b0, ce},   {31'b0, vecs[i].exp_ce});
      check($sformatf("vec%0d pend", i), {31'b0, pend}, {31'b0, vecs[i].exp_pend});
      check($sformatf("vec%0d state", i), {30'b0, dbg},
            {30'b0, exp_state(vecs[i].exp_ce, vecs[i].exp_pend)});
    end

    // random run against the model
    m_pc = 0; m_tgt = 0; m_ce = 0; m_pend = 0;
    for (int i = 0; i < 400; i++) begin
      logic r, s, f, b;
      logic [31:0] np, t;
      r = (i < 2) || ($urandom_range(0, 59) == 0);
      s = ($urandom_range(0, 2) == 0);
      f = ($urandom_range(0, 9) == 0);
      b = ($urandom_range(0, 3) == 0);
      np = $urandom;
      t  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      model_step(r, s, f, np, b, t);
      drive(r, s, f, np, b, t);
      e = exp_q.pop_front();
      check($sformatf("rand%0d pc", i),   pc,   e[31:0]);
      check($sformatf("rand%0d ce", i),   {31'b0, ce},   {31'b0, e[33]});
      check($sformatf("rand%0d pend", i), {31'b0, pend}, {31'b0, e[32]});
    end

    // 8-bit instance: wrap from 0xFC to 0x00 and target alignment
    drive8(1,0,0,8'h00,0,8'h00);
    check("w8 reset ce", {31'b0, ce8}, 32'd0);
    check("w8 reset pc", {24'b0, pc8}, 32'h00);
    drive8(0,0,0,8'h00,0,8'h00);
    check("w8 release pc", {24'b0, pc8}, 32'h00);
    drive8(0,0,1,8'hFA,0,8'h00);
    check("w8 flush align", {24'b0, pc8}, 32'hF8);
    drive8(0,0,0,8'h00,0,8'h00);
    check("w8 pc FC", {24'b0, pc8}, 32'hFC);
    drive8(0,0,0,8'h00,0,8'h00);
    check("w8 wrap", {24'b0, pc8}, 32'h00);
    drive8(0,0,0,8'h00,1,8'h33);
    check("w8 branch align", {24'b0, pc8}, 32'h30);
    drive8(0,1,0,8'h00,1,8'hFF);
    check("w8 pend set", {31'b0, pend8}, 32'd1);
    check("w8 state pend", {30'b0, dbg8}, {30'b0, PC_PEND});
    drive8(0,0,0,8'h00,0,8'h00);
    check("w8 pend take", {24'b0, pc8}, 32'hFC);
    drive8(0,0,0,8'h00,0,8'h00);
    check("w8 wrap after take", {24'b0, pc8}, 32'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
